// File: rtl/wallace_pkg.sv
// Shared types, widths and carry-save helpers for the Wallace-tree MAC slice.
package wallace_pkg;

    localparam int OP_W   = 8;
    localparam int PROD_W = 16;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } mac_state_t;

    function automatic logic [PROD_W-1:0] csa_sum(
        input logic [PROD_W-1:0] x,
        input logic [PROD_W-1:0] y,
        input logic [PROD_W-1:0] z
    );
        return x ^ y ^ z;
    endfunction

    // The carry that falls off the top is dropped; an 8x8 product always fits in 16 bits.
    function automatic logic [PROD_W-1:0] csa_carry(
        input logic [PROD_W-1:0] x,
        input logic [PROD_W-1:0] y,
        input logic [PROD_W-1:0] z
    );
        return ((x & y) | (x & z) | (y & z)) << 1;
    endfunction

endpackage

// File: rtl/wallace_multiplier.sv
// Combinational unsigned 8x8 multiplier: partial products reduced by a
// four-level carry-save tree, then one carry-propagate add.
module wallace_multiplier
    import wallace_pkg::*;
(
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic [PROD_W-1:0] result
);

    logic [PROD_W-1:0] pp [OP_W];
    logic [PROD_W-1:0] s0, c0, s1, c1, s2, c2, s3, c3, s4, c4, s5, c5;

    // Shifted partial-product rows, one per multiplier bit.
    always_comb begin
        for (int i = 0; i < OP_W; i++) begin
            pp[i] = {8'h00, a & {OP_W{b[i]}}} << i;
        end
    end

    // Reduction: 8 rows -> 6 -> 4 -> 3 -> 2.
    assign s0 = csa_sum  (pp[0], pp[1], pp[2]);
    assign c0 = csa_carry(pp[0], pp[1], pp[2]);
    assign s1 = csa_sum  (pp[3], pp[4], pp[5]);
    assign c1 = csa_carry(pp[3], pp[4], pp[5]);
    assign s2 = csa_sum  (s0, c0, s1);
    assign c2 = csa_carry(s0, c0, s1);
    assign s3 = csa_sum  (c1, pp[6], pp[7]);
    assign c3 = csa_carry(c1, pp[6], pp[7]);
    assign s4 = csa_sum  (s2, c2, s3);
    assign c4 = csa_carry(s2, c2, s3);
    assign s5 = csa_sum  (s4, c4, c3);
    assign c5 = csa_carry(s4, c4, c3);

    assign result = s5 + c5;

endmodule

// File: rtl/wallace_mac_accumulator.sv
// Streaming dot-product unit: accepts VEC_LEN operand pairs, accumulates their
// products and offers the wrapped sum plus a sticky carry-out flag downstream.
module wallace_mac_accumulator
    import wallace_pkg::*;
#(
    parameter int VEC_LEN = 4,
    parameter int ACC_W   = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  a,
    input  logic [OP_W-1:0]  b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_overflow
);

    localparam int COUNT_W = $clog2(VEC_LEN + 1);

    mac_state_t         state;
    logic [COUNT_W-1:0] count;
    logic [OP_W-1:0]    a_r;
    logic [OP_W-1:0]    b_r;
    logic               p_valid;
    logic [ACC_W-1:0]   acc;
    logic               ovf;
    logic [PROD_W-1:0]  prod;
    logic [ACC_W:0]     sum_ext;
    logic               accept;
    logic               last_pair;

    wallace_multiplier u_mult (
        .a      (a_r),
        .b      (b_r),
        .result (prod)
    );

    assign in_ready  = (state == ACCUM) && !rst;
    assign accept    = in_valid && in_ready;
    assign last_pair = (count == COUNT_W'(VEC_LEN - 1));
    assign sum_ext   = {1'b0, acc} + (ACC_W + 1)'(prod);

    // Operand capture, product accumulation, vector FSM and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ACCUM;
            count        <= '0;
            a_r          <= '0;
            b_r          <= '0;
            p_valid      <= 1'b0;
            acc          <= '0;
            ovf          <= 1'b0;
            out_valid    <= 1'b0;
            out_sum      <= '0;
            out_overflow <= 1'b0;
        end else begin
            if (accept) begin
                a_r   <= a;
                b_r   <= b;
                count <= count + COUNT_W'(1);
            end
            p_valid <= accept;
            if (p_valid) begin
                acc <= sum_ext[ACC_W-1:0];
                ovf <= ovf | sum_ext[ACC_W];
            end
            case (state)
                ACCUM: begin
                    if (accept && last_pair) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // The final product lands in acc on this edge.
                    state <= HOLD;
                end
                HOLD: begin
                    if (!out_valid) begin
                        out_valid    <= 1'b1;
                        out_sum      <= acc;
                        out_overflow <= ovf;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        acc       <= '0;
                        ovf       <= 1'b0;
                        count     <= '0;
                        state     <= ACCUM;
                    end
                end
                default: begin
                    state <= ACCUM;
                end
            endcase
        end
    end

endmodule
